// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limit and reference sum for the ripple-carry adder
package full_adder_pkg;

   localparam int MAX_WIDTH = 64;

   // Exact {carry, sum} of a + b + c, keeping only the low `width` bits of each operand.
   function automatic logic [MAX_WIDTH:0] full_adder_ref(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 c,
      input int unsigned          width
   );
      logic [MAX_WIDTH:0] mask;
      mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << width) - {{MAX_WIDTH{1'b0}}, 1'b1};
      return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{MAX_WIDTH{1'b0}}, c};
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with optional registered output stage
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic [WIDTH-1:0] Sum,
   output logic             Cy,
   output logic             out_valid
);

   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_s;

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("full_adder: WIDTH out of range");
   end

   assign w_c[0] = C;

   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a  (A[i]),
         .b  (B[i]),
         .ci (w_c[i]),
         .s  (w_s[i]),
         .co (w_c[i+1])
      );
   end

   if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic             r_cy;
      logic             r_valid;
      // capture the ripple result on valid input, hold it otherwise; reset clears everything
      always_ff @(posedge clk) begin
         if (rst) begin
            r_sum   <= '0;
            r_cy    <= 1'b0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= in_valid;
            if (in_valid) begin
               r_sum <= w_s;
               r_cy  <= w_c[WIDTH];
            end
         end
      end
      assign Sum       = r_sum;
      assign Cy        = r_cy;
      assign out_valid = r_valid;
   end else begin : g_comb
      assign Sum       = w_s;
      assign Cy        = w_c[WIDTH];
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of full_adder against an arithmetic model
module tb_full_adder;
   import full_adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst, v, c;
   logic [15:0] a, b;
   logic        chk_en = 1'b0;
   int          total = 0;
   int          bad = 0;

   logic        s_c1, cy_c1, ov_c1;
   logic        s_r1, cy_r1, ov_r1;
   logic [7:0]  s_r8;
   logic        cy_r8, ov_r8;
   logic [15:0] s_r16;
   logic        cy_r16, ov_r16;

   logic [64:0] m1, m8, m16;
   logic        mv;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(v), .A(a[0:0]), .B(b[0:0]), .C(c),
      .Sum(s_c1), .Cy(cy_c1), .out_valid(ov_c1));
   full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
      .clk(clk), .rst(rst), .in_valid(v), .A(a[0:0]), .B(b[0:0]), .C(c),
      .Sum(s_r1), .Cy(cy_r1), .out_valid(ov_r1));
   full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
      .clk(clk), .rst(rst), .in_valid(v), .A(a[7:0]), .B(b[7:0]), .C(c),
      .Sum(s_r8), .Cy(cy_r8), .out_valid(ov_r8));
   full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_r16 (
      .clk(clk), .rst(rst), .in_valid(v), .A(a), .B(b), .C(c),
      .Sum(s_r16), .Cy(cy_r16), .out_valid(ov_r16));

   function automatic logic [64:0] mdl(input int w, input logic [63:0] x, input logic [63:0] y, input logic ci);
      logic [64:0] m;
      m = (65'd1 << w) - 65'd1;
      return ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, ci};
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // model of the registered adders: result of the last valid input, cleared by reset
   always @(posedge clk) begin
      if (rst) begin
         m1  <= '0;
         m8  <= '0;
         m16 <= '0;
         mv  <= 1'b0;
      end else begin
         mv <= v;
         if (v) begin
            m1  <= mdl(1,  {48'd0, a}, {48'd0, b}, c);
            m8  <= mdl(8,  {48'd0, a}, {48'd0, b}, c);
            m16 <= mdl(16, {48'd0, a}, {48'd0, b}, c);
         end
      end
   end

   // compare every instance against the model once per cycle, away from the rising edge
   always @(negedge clk) begin
      logic [64:0] t;
      if (chk_en) begin
         t = mdl(1, {48'd0, a}, {48'd0, b}, c);
         chk("c1",  {62'd0, ov_c1, cy_c1, s_c1},    {62'd0, v, t[1:0]});
         chk("r1",  {62'd0, ov_r1, cy_r1, s_r1},    {62'd0, mv, m1[1:0]});
         chk("r8",  {55'd0, ov_r8, cy_r8, s_r8},    {55'd0, mv, m8[8:0]});
         chk("r16", {47'd0, ov_r16, cy_r16, s_r16}, {47'd0, mv, m16[16:0]});
      end
   end

   initial begin
      logic [7:0]  sum_t, cy_t;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vc [3];
      logic [8:0]  ve [3];
      sum_t = 8'b1001_0110;
      cy_t  = 8'b1110_1000;
      va = '{16'h00FF, 16'h00FF, 16'h0012};
      vb = '{16'h0000, 16'h00FF, 16'h0034};
      vc = '{1'b1, 1'b1, 1'b0};
      ve = '{9'h100, 9'h1FF, 9'h046};
      rst = 1'b1; v = 1'b0; a = '0; b = '0; c = 1'b0;
      repeat (2) tick();
      chk_en = 1'b1;
      chk("reset_r16", {47'd0, ov_r16, cy_r16, s_r16}, 65'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a[0] = i[2]; b[0] = i[1]; c = i[0]; v = 1'b1;
         #1;
         chk("sweep_c1", {63'd0, cy_c1, s_c1}, {63'd0, cy_t[i], sum_t[i]});
         tick();
         chk("sweep_r1", {62'd0, ov_r1, cy_r1, s_r1}, {62'd0, 1'b1, cy_t[i], sum_t[i]});
      end
      for (int i = 0; i < 3; i++) begin
         a = va[i]; b = vb[i]; c = vc[i]; v = 1'b1;
         tick();
         chk("w8_vec", {56'd0, cy_r8, s_r8}, {56'd0, ve[i]});
      end
      a = 16'd3; b = 16'd4; c = 1'b0; v = 1'b1;
      tick();
      chk("hold_load", {47'd0, ov_r16, cy_r16, s_r16}, {47'd0, 2'b10, 16'd7});
      v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         tick();
         chk("hold", {47'd0, ov_r16, cy_r16, s_r16}, {47'd0, 2'b00, 16'd7});
      end
      a = 16'd100; b = 16'd200; c = 1'b0; v = 1'b1;
      tick();
      rst = 1'b1; a = 16'd5;
      tick();
      chk("rst_mid", {47'd0, ov_r16, cy_r16, s_r16}, 65'd0);
      tick();
      chk("rst_hold", {47'd0, ov_r16, cy_r16, s_r16}, 65'd0);
      rst = 1'b0; a = 16'd10; b = 16'd20; c = 1'b1;
      tick();
      chk("rst_release", {47'd0, ov_r16, cy_r16, s_r16}, {47'd0, 2'b10, 16'd31});
      a = 16'hFFFF; b = 16'h0000; c = 1'b1;
      tick();
      chk("w16_wrap", {47'd0, ov_r16, cy_r16, s_r16}, {47'd0, 2'b11, 16'd0});
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         v = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         chk("pkg_ref", full_adder_ref({48'd0, a}, {48'd0, b}, c, 16), mdl(16, {48'd0, a}, {48'd0, b}, c));
         tick();
      end
      rst = 1'b0; v = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
